// File: rtl/mio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mio_arbiter                                                              |
// | Two-requester (CPU / VGA) arbiter for the single-port system memory.     |
// | Optional macro MIO_VGA_PRIORITY_EN: VGA wins every tie instead of RR.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mio_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ready,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             pick_vga;
    logic             any_req;

    assign any_req   = cpu_req | vga_req;
    assign state_out = state;

    // Winner selection: a lone requester always wins; ties go by policy.
    always_comb begin
        pick_vga = vga_req;
        if (cpu_req && vga_req) begin
`ifdef MIO_VGA_PRIORITY_EN
            pick_vga = 1'b1;
`else
            pick_vga = ~last_grant;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ready  <= 1'b0;
            vga_ready  <= 1'b0;
            cpu_rdata  <= '0;
            vga_rdata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            vga_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick_vga;
                        last_grant <= pick_vga;
                        cnt        <= CNT_INIT;
                        mem_en     <= 1'b1;
                        mem_we     <= pick_vga ? 1'b0 : cpu_we;
                        mem_addr   <= pick_vga ? vga_addr : cpu_addr;
                        mem_wdata  <= pick_vga ? '0 : cpu_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Writes leave both read-data registers untouched.
                        if (!mem_we) begin
                            if (grant) begin
                                vga_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        cpu_ready <= ~grant;
                        vga_ready <= grant;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    grant     <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    cpu_rdata <= '0;
                    vga_rdata <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mio_arbiter                                                           |
// | Directed table, corner sequences and random traffic for mio_arbiter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mio_arbiter;

    localparam int MEM_LAT = 2;
`ifdef MIO_VGA_PRIORITY_EN
    localparam bit TIE_VGA = 1'b1;
`else
    localparam bit TIE_VGA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, vga_req;
    logic [31:0] cpu_addr, cpu_wdata, vga_addr;
    logic        cpu_ready, vga_ready, mem_en, mem_we, grant;
    logic [31:0] cpu_rdata, vga_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h3c03f000;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = mem_val(mem_addr);

    mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ready(vga_ready), .vga_rdata(vga_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .state_out(state_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        vga_req;
        logic [31:0] vga_addr;
        logic        hold;
        logic        exp_grant_rr;
        logic        exp_grant_pri;
        logic        exp_mem_we;
    } vec_t;

    vec_t vecs[6];

    // Transaction-level reference: position inside the MEM_LAT+2 cycle window.
    int          m_t;
    bit          m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata, m_crd, m_vrd;

    task automatic model_reset();
        m_t = 0; m_owner = 0; m_last = 1; m_we = 0;
        m_addr = '0; m_wdata = '0; m_crd = '0; m_vrd = '0;
    endtask

    task automatic model_edge();
        bit v;
        if (m_t == 0) begin
            if (cpu_req || vga_req) begin
                v = (cpu_req && vga_req) ? (TIE_VGA ? 1'b1 : !m_last) : vga_req;
                m_owner = v; m_last = v;
                m_addr  = v ? vga_addr : cpu_addr;
                m_we    = v ? 1'b0 : cpu_we;
                m_wdata = cpu_wdata;
                m_t     = 1;
            end
        end else if (m_t <= MEM_LAT) begin
            if (m_t == MEM_LAT && !m_we) begin
                if (m_owner) m_vrd = mem_val(m_addr);
                else         m_crd = mem_val(m_addr);
            end
            m_t++;
        end else begin
            m_t = 0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic        g;
        logic [31:0] ea, exp_crd, exp_vrd;
        int          ncpu, nvga;

        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h2014003f, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h84, 32'hdeadbeef, 1'b1, 32'h48, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h88, 32'h0,        1'b1, 32'h4c, 1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 0; vga_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);       chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_ready", cpu_ready, 0); chk("rst_vga_ready", vga_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_vga_rdata", vga_rdata, 0);
        chk("rst_grant", grant, 0);         chk("rst_state", state_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_state", state_out, 0);

        exp_crd = '0; exp_vrd = '0;
        for (int j = 0; j < 6; j++) begin
            g  = TIE_VGA ? vecs[j].exp_grant_pri : vecs[j].exp_grant_rr;
            ea = g ? vecs[j].vga_addr : vecs[j].cpu_addr;
            cpu_req = vecs[j].cpu_req; cpu_we = vecs[j].cpu_we;
            cpu_addr = vecs[j].cpu_addr; cpu_wdata = vecs[j].cpu_wdata;
            vga_req = vecs[j].vga_req; vga_addr = vecs[j].vga_addr;
            @(posedge clk); #1;
            chk("v_state_acc", state_out, 1); chk("v_grant", grant, g);
            chk("v_mem_en", mem_en, 1);       chk("v_mem_addr", mem_addr, ea);
            chk("v_mem_we", mem_we, vecs[j].exp_mem_we);
            if (vecs[j].exp_mem_we) chk("v_mem_wdata", mem_wdata, vecs[j].cpu_wdata);
            if (!vecs[j].hold) begin cpu_req = 0; vga_req = 0; end
            for (int k = 1; k < MEM_LAT; k++) begin
                @(posedge clk); #1;
                chk("v_state_acc2", state_out, 1); chk("v_mem_en2", mem_en, 1);
                chk("v_mem_addr2", mem_addr, ea);
                chk("v_mem_we2", mem_we, vecs[j].exp_mem_we);
            end
            @(posedge clk); #1;
            if (!vecs[j].exp_mem_we) begin
                if (g) exp_vrd = mem_val(ea);
                else   exp_crd = mem_val(ea);
            end
            chk("v_state_done", state_out, 2); chk("v_done_en", mem_en, 0);
            chk("v_done_we", mem_we, 0);
            chk("v_cpu_ready", cpu_ready, !g); chk("v_vga_ready", vga_ready, g);
            chk("v_cpu_rdata", cpu_rdata, exp_crd); chk("v_vga_rdata", vga_rdata, exp_vrd);
            cpu_req = 0; vga_req = 0;
            @(posedge clk); #1;
            chk("v_state_idle", state_out, 0); chk("v_idle_en", mem_en, 0);
            chk("v_idle_cpu_ready", cpu_ready, 0); chk("v_idle_vga_ready", vga_ready, 0);
        end
        @(posedge clk); #1;
        chk("idle_no_en", mem_en, 0);

        // Reset in the second ACCESS cycle of a CPU read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h90;
        @(posedge clk); #1;
        chk("ra_state1", state_out, 1);
        @(posedge clk); #1;
        chk("ra_state2", state_out, 1);
        reset = 1'b0;
        #1;
        chk("ra_mem_en", mem_en, 0); chk("ra_mem_we", mem_we, 0); chk("ra_state", state_out, 0);
        cpu_req = 0;
        @(posedge clk); #1;
        chk("ra_no_ready", cpu_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1; cpu_addr = 32'h10; vga_req = 1; vga_addr = 32'h40;
        @(posedge clk); #1;
        chk("ra_tie_grant", grant, TIE_VGA);
        cpu_req = 0; vga_req = 0;
        repeat (MEM_LAT + 1) @(posedge clk);
        #1;

        // Both requesters held continuously.
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; vga_req = 1; vga_addr = 32'h200;
        ncpu = 0; nvga = 0;
        for (int c = 0; c < 4 * (MEM_LAT + 2); c++) begin
            @(posedge clk); #1;
            chk("cont_no_overlap", cpu_ready & vga_ready, 0);
            if (cpu_ready) ncpu++;
            if (vga_ready) nvga++;
        end
        chk("cont_cpu_pulses", ncpu, TIE_VGA ? 0 : 2);
        chk("cont_vga_pulses", nvga, TIE_VGA ? 4 : 2);
        cpu_req = 0; vga_req = 0;

        // Random traffic against the reference model.
        pulse_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            bit cpu_done, vga_done;
            @(posedge clk);
            model_edge();
            #1;
            chk("r_state", state_out, m_t == 0 ? 0 : (m_t <= MEM_LAT ? 1 : 2));
            chk("r_mem_en", mem_en, m_t >= 1 && m_t <= MEM_LAT);
            chk("r_mem_we", mem_we, m_t >= 1 && m_t <= MEM_LAT && m_we);
            if (m_t >= 1 && m_t <= MEM_LAT) begin
                chk("r_mem_addr", mem_addr, m_addr);
                if (m_we) chk("r_mem_wdata", mem_wdata, m_wdata);
            end
            chk("r_cpu_ready", cpu_ready, m_t == MEM_LAT + 1 && !m_owner);
            chk("r_vga_ready", vga_ready, m_t == MEM_LAT + 1 && m_owner);
            chk("r_grant", grant, m_owner);
            chk("r_cpu_rdata", cpu_rdata, m_crd);
            chk("r_vga_rdata", vga_rdata, m_vrd);
            cpu_done = (m_t == MEM_LAT + 1) && !m_owner;
            vga_done = (m_t == MEM_LAT + 1) && m_owner;
            if (!cpu_req || cpu_done) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom & 32'h0000fffc;
                cpu_wdata = $urandom;
            end
            if (!vga_req || vga_done) begin
                vga_req  = ($urandom_range(0, 2) != 0);
                vga_addr = $urandom & 32'h0000fffc;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
